// File: rtl/matmul_engine.sv
// N x N matrix-multiply engine: reads A/B row-major through a 1-cycle-latency port,
// accumulates at full width, and writes saturated 2*DW-bit results as two little-endian words.
module matmul_engine #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_signed_mode,
  input  logic [AW-1:0] i_base_a,
  input  logic [AW-1:0] i_base_b,
  input  logic [AW-1:0] i_base_c,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_overflow,
  output logic          o_mem_rd_en,
  output logic [AW-1:0] o_mem_rd_addr,
  input  logic [DW-1:0] i_mem_rd_data,
  output logic          o_mem_wr_en,
  output logic [AW-1:0] o_mem_wr_addr,
  output logic [DW-1:0] o_mem_wr_data
);

  localparam int unsigned RW   = 2 * DW;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned ACCW = RW + IW;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR_LO, WR_HI, FIN} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_i, r_j, r_k;
  logic [ACCW-1:0] r_acc;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_hi;
  logic            r_signed;
  logic [AW-1:0]   r_base_a, r_base_b, r_base_c;

  logic [ACCW-1:0] w_a_ext, w_b_ext, w_prod, w_sum;
  logic [RW-1:0]   w_sat;
  logic            w_clamp;
  logic            w_last_k, w_last_j, w_last_i;
  logic [IW-1:0]   w_i_nx, w_j_nx;
  logic [AW-1:0]   w_c_addr;

  function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] base,
                                           input logic [IW-1:0] row,
                                           input logic [IW-1:0] col);
    return base + AW'(row) * AW'(N) + AW'(col);
  endfunction

  // Operand extension follows the mode latched at start.
  assign w_a_ext = r_signed ? {{(ACCW-DW){r_a[DW-1]}}, r_a} : {{(ACCW-DW){1'b0}}, r_a};
  assign w_b_ext = r_signed ? {{(ACCW-DW){i_mem_rd_data[DW-1]}}, i_mem_rd_data}
                            : {{(ACCW-DW){1'b0}}, i_mem_rd_data};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_sum   = r_acc + w_prod;

  always_comb begin
    w_sat   = w_sum[RW-1:0];
    w_clamp = 1'b0;
    if (r_signed) begin
      if (w_sum[ACCW-1:RW-1] != {(IW+1){w_sum[ACCW-1]}}) begin
        w_clamp = 1'b1;
        w_sat   = w_sum[ACCW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
      end
    end else if (w_sum[ACCW-1:RW] != '0) begin
      w_clamp = 1'b1;
      w_sat   = '1;
    end
  end

  assign w_last_k = (r_k == IW'(N-1));
  assign w_last_j = (r_j == IW'(N-1));
  assign w_last_i = (r_i == IW'(N-1));
  assign w_j_nx   = w_last_j ? '0 : IW'(r_j + 1'b1);
  assign w_i_nx   = w_last_j ? IW'(r_i + 1'b1) : r_i;
  assign w_c_addr = r_base_c + AW'(2) * (AW'(r_i) * AW'(N) + AW'(r_j));

  // Controller; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_acc         <= '0;
      r_a           <= '0;
      r_hi          <= '0;
      r_signed      <= 1'b0;
      r_base_a      <= '0;
      r_base_b      <= '0;
      r_base_c      <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_overflow    <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_mem_rd_addr <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base_a      <= i_base_a;
            r_base_b      <= i_base_b;
            r_base_c      <= i_base_c;
            r_signed      <= i_signed_mode;
            o_overflow    <= 1'b0;
            r_acc         <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            o_busy        <= 1'b1;
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= i_base_a;
            r_state       <= RD_A;
          end
        end
        RD_A: begin
          o_mem_rd_addr <= f_addr(r_base_b, r_k, r_j);
          r_state       <= RD_B;
        end
        RD_B: begin
          r_a         <= i_mem_rd_data;
          o_mem_rd_en <= 1'b0;
          r_state     <= MAC;
        end
        MAC: begin
          r_acc <= w_sum;
          if (!w_last_k) begin
            r_k           <= IW'(r_k + 1'b1);
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= f_addr(r_base_a, r_i, IW'(r_k + 1'b1));
            r_state       <= RD_A;
          end else begin
            o_mem_wr_en   <= 1'b1;
            o_mem_wr_addr <= w_c_addr;
            o_mem_wr_data <= w_sat[DW-1:0];
            r_hi          <= w_sat[RW-1:DW];
            if (w_clamp) o_overflow <= 1'b1;
            r_state       <= WR_LO;
          end
        end
        WR_LO: begin
          o_mem_wr_addr <= o_mem_wr_addr + 1'b1;
          o_mem_wr_data <= r_hi;
          r_state       <= WR_HI;
        end
        WR_HI: begin
          o_mem_wr_en <= 1'b0;
          r_acc       <= '0;
          r_k         <= '0;
          r_j         <= w_j_nx;
          r_i         <= w_i_nx;
          if (w_last_i && w_last_j) begin
            r_state <= FIN;
          end else begin
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= f_addr(r_base_a, w_i_nx, '0);
            r_state       <= RD_A;
          end
        end
        FIN: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
